uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//   Receive buffer directly downstream of the UART receiver. Detects each completed
//   frame (rising edge of the receiver's level-type rx_ready flag) and stores the byte
//   in a circular FIFO. Presents a first-word-fall-through read port to the consumer.
//   Drops error frames and keeps a count of them.
// PARAMETERS
//   DEPTH   16   FIFO entries; power of 2, >= 2
//   AW      $clog2(DEPTH)   pointer index width; derived localparam, not overridable
// PORTS
//   clk50m     in   1      system clock, all logic on posedge
//   rst_n      in   1      asynchronous reset, active low
//   rx_data    in   8      received byte from UART receiver
//   rx_ready   in   1      level flag; rising edge = frame complete
//   rx_error   in   1      frame error flag, valid in the rx_ready rising-edge cycle
//   rd_en      in   1      pop request; honoured only when rd_valid=1
//   rd_data    out  8      head entry (FWFT, combinational from memory at rd_ptr)
//   rd_valid   out  1      FIFO not empty
//   rd_err     out  1      head entry error bit (only with UART_RX_FIFO_ERRBIT_EN)
//   fill       out  AW+1   number of stored entries, 0..DEPTH
//   full       out  1      fill == DEPTH
//   overflow   out  1      sticky: a byte was lost because FIFO was full
//   ovf_clr    in   1      synchronous clear of overflow
//   err_cnt    out  8      count of error frames, saturates at 255
// BEHAVIOUR
//   Reset: wr_ptr=rd_ptr=0, fill=0, rd_valid=0, full=0, overflow=0, err_cnt=0.
//     rx_ready_q resets to 1, so a flag already high at reset release is not captured.
//     Memory contents are not reset; rd_data is don't-care while rd_valid=0.
//   Edge detect: rx_ready_q <= rx_ready each cycle; wr_evt = rx_ready & ~rx_ready_q.
//     rx_data and rx_error are sampled in the wr_evt cycle.
//   Pointers: AW+1 bits with a wrap bit. Full/empty come from comparing the pointers.
//     fill = wr_ptr - rd_ptr, modulo 2^(AW+1).
//   Write (wr_evt, frame accepted): mem[wr_ptr[AW-1:0]] <= rx_data; wr_ptr++ next edge.
//   Read: pop = rd_en & rd_valid -> rd_ptr++ next edge. rd_en while empty is ignored
//     and has no side effects.
//   Latency: byte visible on rd_data/rd_valid 1 cycle after the wr_evt cycle.
//   Simultaneous pop + write:
//     - not full: both happen, fill unchanged.
//     - full: pop frees a slot, write accepted, fill stays DEPTH, no overflow.
//     - empty: pop ignored (rd_valid=0), write accepted.
//   Overflow: wr_evt while full and no pop -> byte dropped, pointers unchanged,
//     overflow <= 1.
//   ovf_clr: clears overflow. If ovf_clr and a new overflow occur in the same cycle,
//     the set wins.
//   Error frames (wr_evt & rx_error): err_cnt increments, saturating at 255.
//     Storage depends on the macro (see CONFIGURATION).
//   A dropped error frame never sets overflow.
//   Reset mid-operation: all state returns to reset values immediately; stored data
//     is lost.
// CONFIGURATION
//   UART_RX_FIFO_ERRBIT_EN
//     Undefined: error frames are discarded (not written); rd_err port is absent.
//     Defined: each entry is 9 bits {err,data}. Error frames are stored like good
//       frames, with err=1. rd_err = err bit of the head entry. err_cnt still counts.
// TESTING
//   T1 reset: rx_ready held 1 through reset release
//      -> no write; rd_valid=0, fill=0, err_cnt=0.
//   T2 single byte: rx_data=8'hA5, rx_ready 0->1
//      -> next cycle rd_valid=1, rd_data=A5, fill=1; after rd_en pulse rd_valid=0.
//   T3 fill/overflow (DEPTH=16): write 0x00..0x0F -> full=1.
//      Write 0x10 -> overflow=1, fill=16.
//      Drain 16 reads -> data 0x00..0x0F in order.
//      Pulse ovf_clr -> overflow=0.
//   T4 simultaneous: FIFO full, wr_evt(8'h55) with rd_en
//      -> fill=16, overflow=0, 8'h55 read out last.
//      On empty FIFO, rd_en + wr_evt -> fill=1.
//   T5 error: rx_error=1 with rx_data=8'h3C on the edge
//      -> err_cnt=1; no macro: fill=0; macro: rd_data=3C, rd_err=1.
//      Drive 300 error frames -> err_cnt=255.
//   T6 pointer wrap: 40 write/read pairs with DEPTH=16
//      -> data order preserved, fill returns to 0, full never set.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: edge-detects rx_ready, buffers bytes, FWFT read port.
// Optional UART_RX_FIFO_ERRBIT_EN stores error frames with a per-entry error bit and adds rd_err.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk50m,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_ready,
    input  logic          rx_error,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
`ifdef UART_RX_FIFO_ERRBIT_EN
    output logic          rd_err,
`endif
    output logic [AW:0]   fill,
    output logic          full,
    output logic          overflow,
    input  logic          ovf_clr,
    output logic [7:0]    err_cnt
);

`ifdef UART_RX_FIFO_ERRBIT_EN
    localparam int EW = 9;
`else
    localparam int EW = 8;
`endif
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          rx_ready_q;
    logic          overflow_q, overflow_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic          wr_evt, store_frame, wr_acc, pop, ovf_set, empty;
    logic [EW-1:0] wr_entry, head;

    assign wr_evt = rx_ready & ~rx_ready_q;
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop    = rd_en & ~empty;

`ifdef UART_RX_FIFO_ERRBIT_EN
    assign store_frame = wr_evt;
    assign wr_entry    = {rx_error, rx_data};
`else
    assign store_frame = wr_evt & ~rx_error;
    assign wr_entry    = rx_data;
`endif

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign wr_acc  = store_frame & (~full | pop);
    assign ovf_set = wr_evt & ~rx_error & full & ~pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        err_cnt_d  = err_cnt_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)    rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (ovf_set)      overflow_d = 1'b1;
        else if (ovf_clr) overflow_d = 1'b0;
        if (wr_evt && rx_error && (err_cnt_q != 8'hFF))
            err_cnt_d = err_cnt_q + 8'd1;
    end

    // rx_ready_q resets high so a flag already asserted at reset release is ignored.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rx_ready_q <= 1'b1;
            overflow_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rx_ready_q <= rx_ready;
            overflow_q <= overflow_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    always_ff @(posedge clk50m) begin
        if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
    end

    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign rd_data  = head[7:0];
`ifdef UART_RX_FIFO_ERRBIT_EN
    assign rd_err   = head[8];
`endif
    assign rd_valid = ~empty;
    assign fill     = wr_ptr_q - rd_ptr_q;
    assign overflow = overflow_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: expected entries queued on each frame, checked on each pop.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
`ifdef UART_RX_FIFO_ERRBIT_EN
    localparam bit ERRBIT = 1'b1;
`else
    localparam bit ERRBIT = 1'b0;
`endif

    logic       clk50m = 1'b0;
    logic       rst_n, rx_ready, rx_error, rd_en, ovf_clr;
    logic [7:0] rx_data, rd_data, err_cnt;
    logic       rd_valid, full, overflow;
    logic [4:0] fill;
`ifdef UART_RX_FIFO_ERRBIT_EN
    logic       rd_err;
`endif

    int total = 0;
    int bad   = 0;
    logic [8:0] sb[$];
    bit   ovf_m = 1'b0;
    int   err_m = 0;

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk50m  (clk50m),
        .rst_n   (rst_n),
        .rx_data (rx_data),
        .rx_ready(rx_ready),
        .rx_error(rx_error),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
`ifdef UART_RX_FIFO_ERRBIT_EN
        .rd_err  (rd_err),
`endif
        .fill    (fill),
        .full    (full),
        .overflow(overflow),
        .ovf_clr (ovf_clr),
        .err_cnt (err_cnt)
    );

    always #10 clk50m = ~clk50m;

    initial begin
        #2ms;
        $display("FAIL watchdog: run time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk50m);
        #1;
    endtask

    // One receiver frame: rx_ready high for a cycle, then low again.
    task automatic send_byte(input logic [7:0] d, input logic err);
        rx_data  = d;
        rx_error = err;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        rx_error = 1'b0;
        tick();
        if (err && err_m < 255) err_m++;
        if (err && !ERRBIT) begin
        end else if (sb.size() == DEPTH) begin
            if (!err) ovf_m = 1'b1;
        end else begin
            sb.push_back({err, d});
        end
    endtask

    task automatic rd_one();
        logic [8:0] e;
        e = sb.pop_front();
        chk("rd_valid", rd_valid, 1);
        chk("rd_data", rd_data, e[7:0]);
`ifdef UART_RX_FIFO_ERRBIT_EN
        chk("rd_err", rd_err, e[8]);
`endif
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic drain();
        while (sb.size() > 0) rd_one();
        chk("drain_valid", rd_valid, 0);
        chk("drain_fill", fill, 0);
    endtask

    initial begin
        logic [8:0] e;
        rst_n = 1'b0; rx_ready = 1'b1; rx_error = 1'b0; rx_data = 8'h00;
        rd_en = 1'b0; ovf_clr = 1'b0;

        // T1: flag high across reset release must not be captured
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("t1_valid", rd_valid, 0);
        chk("t1_fill", fill, 0);
        chk("t1_err", err_cnt, 0);
        chk("t1_ovf", overflow, 0);
        chk("t1_full", full, 0);
        rx_ready = 1'b0;
        tick();

        // T2: single byte, one-cycle latency
        rx_data = 8'hA5; rx_ready = 1'b1;
        tick();
        chk("t2_valid", rd_valid, 1);
        chk("t2_data", rd_data, 8'hA5);
        chk("t2_fill", fill, 1);
        rx_ready = 1'b0;
        tick();
        sb.push_back({1'b0, 8'hA5});
        rd_one();
        chk("t2_empty", rd_valid, 0);

        // T3: fill, overflow, set-beats-clear, drain, clear
        for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 1'b0);
        chk("t3_full", full, 1);
        chk("t3_fill", fill, DEPTH);
        chk("t3_ovf0", overflow, 0);
        send_byte(8'h10, 1'b0);
        chk("t3_ovf1", overflow, ovf_m);
        chk("t3_fill2", fill, DEPTH);
        rx_data = 8'h11; rx_ready = 1'b1; ovf_clr = 1'b1;
        tick();
        rx_ready = 1'b0; ovf_clr = 1'b0;
        tick();
        chk("t3_setwins", overflow, 1);
        drain();
        chk("t3_ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t3_ovfclr", overflow, 0);
        ovf_m = 1'b0;

        // T4: simultaneous pop + write on full, then on empty
        for (int i = 0; i < DEPTH; i++) send_byte(8'h20 + 8'(i), 1'b0);
        e = sb.pop_front();
        chk("t4_head", rd_data, e[7:0]);
        rx_data = 8'h55; rx_ready = 1'b1; rd_en = 1'b1;
        tick();
        rx_ready = 1'b0; rd_en = 1'b0;
        sb.push_back({1'b0, 8'h55});
        tick();
        chk("t4_fill", fill, DEPTH);
        chk("t4_ovf", overflow, 0);
        chk("t4_full", full, 1);
        drain();
        rx_data = 8'h66; rx_ready = 1'b1; rd_en = 1'b1;
        tick();
        rx_ready = 1'b0; rd_en = 1'b0;
        sb.push_back({1'b0, 8'h66});
        tick();
        chk("t4_efill", fill, 1);
        drain();

        // T5: error frames and counter saturation
        send_byte(8'h3C, 1'b1);
        chk("t5_cnt1", err_cnt, 1);
        chk("t5_fill", fill, ERRBIT ? 1 : 0);
        if (ERRBIT) rd_one();
        for (int i = 0; i < 299; i++) send_byte(8'(i), 1'b1);
        chk("t5_cntsat", err_cnt, err_m);
        chk("t5_cnt255", err_cnt, 255);
        chk("t5_noovf", overflow, 0);
        chk("t5_fill2", fill, sb.size());
        drain();

        // T6: pointer wrap with interleaved write/read
        for (int i = 0; i < 40; i++) begin
            send_byte(8'($urandom_range(0, 255)), 1'b0);
            chk("t6_full", full, 0);
            rd_one();
        end
        chk("t6_fill", fill, 0);
        chk("t6_valid", rd_valid, 0);

        // Reset mid-operation discards contents
        send_byte(8'h77, 1'b0);
        send_byte(8'h78, 1'b0);
        rst_n = 1'b0;
        #3;
        chk("rst_fill", fill, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_err", err_cnt, 0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
